pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter: DATA_W, 32, payload width in bits (instruction/PC/ALU result bundle).
REQ-002 SHALL have parameter: RD_W, 6, destination-register tag width.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port: flush  input  1  synchronous squash of all held entries.
REQ-006 SHALL have port: in_valid  input  1  upstream presents an entry.
REQ-007 SHALL have port: in_ready  output  1  stage can accept an entry this cycle.
REQ-008 SHALL have port: in_data  input  DATA_W  upstream payload.
REQ-009 SHALL have port: in_rd  input  RD_W  upstream destination tag.
REQ-010 SHALL have port: out_valid  output  1  stage presents an entry downstream.
REQ-011 SHALL have port: out_ready  input  1  downstream accepts this cycle.
REQ-012 SHALL have port: out_data  output  DATA_W  presented payload.
REQ-013 SHALL have port: out_rd  output  RD_W  presented destination tag.
REQ-014 SHALL have port: occupancy  output  2  entries held: 0, 1 or 2.

Function
REQ-015 SHALL implement a two-entry skid buffer: main register (drives outputs) plus one skid register.
REQ-016 SHALL use states EMPTY (0 held), BUSY (main only), FULL (main+skid).
REQ-017 SHALL define accept = in_valid & in_ready and take = out_valid & out_ready.
REQ-018 SHALL drive in_ready = (state != FULL) and out_valid = (state != EMPTY), decoded from registered state only; no combinational path from out_ready to in_ready.
REQ-019 EMPTY: accept -> main <= in, go BUSY; else stay.
REQ-020 BUSY: accept & take -> main <= in, stay BUSY; accept & !take -> skid <= in, go FULL; !accept & take -> go EMPTY; neither -> hold.
REQ-021 FULL: take -> main <= skid, go BUSY; else hold; no input accepted (in_ready = 0).
REQ-022 SHALL give one-cycle latency: an entry accepted in EMPTY appears on out_* the following cycle.
REQ-023 SHALL preserve order; no entry duplicated or dropped except by flush or reset.
REQ-024 SHALL hold out_data/out_rd stable while out_valid=1 and out_ready=0.
REQ-025 flush SHALL take priority over accept/take: next state EMPTY, a same-cycle input is discarded, a same-cycle take is still considered completed downstream.
REQ-026 out_data/out_rd SHALL retain their last values when out_valid=0 (not cleared by flush).
REQ-027 occupancy SHALL equal 0/1/2 for EMPTY/BUSY/FULL.

Reset
REQ-028 rst assertion SHALL immediately force state EMPTY, main and skid payloads to 0, tags to 0, independent of clk.
REQ-029 During and after reset: out_valid=0, in_ready=1, occupancy=0, out_data=0, out_rd=0.
REQ-030 Reset mid-operation SHALL discard all held entries; first accept after deassertion behaves as from EMPTY.

Structure
REQ-031 SHALL place state encoding (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2) and default widths (DATA_W=32, RD_W=6) in shared package pipe_pkg.
REQ-032 SHALL be a single module; no sub-module; one instance replaces each fixed IF/ID, ID/EX, EX/MEM, MEM/WB register.

Verification
REQ-033 Reset then in_valid=1, in_data=0x0000_1234, in_rd=5, out_ready=1 -> next cycle out_valid=1, out_data=0x0000_1234, out_rd=5, occupancy=1.
REQ-034 Back-to-back stream 0x1..0x8 with out_ready=1 constantly -> outputs 0x1..0x8 in order, one per cycle, in_ready never 0.
REQ-035 Send 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA held; raise out_ready -> 0xA then 0xB on consecutive cycles.
REQ-036 In FULL (0xA, 0xB held) assert flush with in_valid=1, in_data=0xC -> next cycle out_valid=0, occupancy=0, in_ready=1; 0xC never appears.
REQ-037 Assert rst asynchronously mid-cycle while BUSY -> out_valid=0, out_data=0, occupancy=0 before next clk edge.
REQ-038 Random in_valid/out_ready (10k cycles) -> scoreboard matches order and count exactly; out_* stable whenever out_valid & !out_ready.

Source files
------------

// File: rtl/pipe_pkg.sv
// Purpose : shared state encoding and default widths for the pipeline stage buffer.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RD_W_DEF   = 6;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/pipe_stage_buf.sv
// Purpose : two-entry skid buffer used as a drop-in pipeline register (IF/ID, ID/EX, ...).
// Latency : one cycle from accept in EMPTY to out_valid.
// Backpressure: in_ready comes from registered state only, so out_ready never reaches it
//   combinationally; the skid entry absorbs the one cycle of slack that this creates.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   flush                    synchronous squash of all held entries
//   in_valid/in_ready        upstream handshake; in_data/in_rd carry the entry
//   out_valid/out_ready      downstream handshake; out_data/out_rd driven by the main register
//   occupancy                entries held (0, 1 or 2)
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        occupancy
);

  buf_state_t        state;
  buf_state_t        state_nxt;
  logic [DATA_W-1:0] main_data;
  logic [RD_W-1:0]   main_rd;
  logic [DATA_W-1:0] skid_data;
  logic [RD_W-1:0]   skid_rd;

  logic accept;
  logic take;
  logic ld_main_in;
  logic ld_main_skid;
  logic ld_skid;

  // Handshake outputs decoded purely from the state register.
  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign occupancy = state;
  assign out_data  = main_data;
  assign out_rd    = main_rd;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;

    case (state)
      ST_EMPTY: begin
        if (accept) begin
          ld_main_in = 1'b1;
          state_nxt  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept && take) begin
          ld_main_in = 1'b1;
        end else if (accept) begin
          ld_skid   = 1'b1;
          state_nxt = ST_FULL;
        end else if (take) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (take) begin
          ld_main_skid = 1'b1;
          state_nxt    = ST_BUSY;
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
      end
    endcase

    // Flush wins: nothing is loaded, so the main register keeps its last
    // payload on out_data/out_rd while out_valid drops.
    if (flush) begin
      state_nxt    = ST_EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      main_data <= '0;
      main_rd   <= '0;
      skid_data <= '0;
      skid_rd   <= '0;
    end else begin
      state <= state_nxt;
      if (ld_main_in) begin
        main_data <= in_data;
        main_rd   <= in_rd;
      end else if (ld_main_skid) begin
        main_data <= skid_data;
        main_rd   <= skid_rd;
      end
      if (ld_skid) begin
        skid_data <= in_data;
        skid_rd   <= in_rd;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  localparam int DW = 32;
  localparam int RW = 6;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [RW-1:0] in_rd;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_rd;
  logic [1:0]    occupancy;

  int checks;
  int errors;

  pipe_stage_buf #(.DATA_W(DW), .RD_W(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          fl;
    logic          iv;
    logic [DW-1:0] idat;
    logic [RW-1:0] ird;
    logic          ordy;
    logic          e_ov;
    logic [DW-1:0] e_dat;
    logic [RW-1:0] e_rd;
    logic [1:0]    e_occ;
    logic          e_ir;
  } vec_t;

  vec_t vecs[14];

  // Post-edge check of every output against one set of expected values.
  task automatic chk_outs(input string tag, input logic ov, input logic [DW-1:0] dat,
                          input logic [RW-1:0] rd, input logic [1:0] occ, input logic ir);
    chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, ov});
    chk({tag, ".out_data"},  {32'd0, out_data},  {32'd0, dat});
    chk({tag, ".out_rd"},    {58'd0, out_rd},    {58'd0, rd});
    chk({tag, ".occupancy"}, {62'd0, occupancy}, {62'd0, occ});
    chk({tag, ".in_ready"},  {63'd0, in_ready},  {63'd0, ir});
  endtask

  logic [DW+RW-1:0] sb_q[$];
  logic [DW+RW-1:0] exp_e;
  logic             pre_acc;
  logic             pre_take;
  logic             pre_hold;
  logic [DW+RW-1:0] pre_out;
  logic [DW+RW-1:0] pre_in;

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_rd     = '0;
    out_ready = 1'b0;

    //            fl    iv    idat          ird    ordy  e_ov  e_dat         e_rd   occ   ir
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_1234, 6'd5, 1'b1, 1'b1, 32'h0000_1234, 6'd5, 2'd1, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         6'd0, 1'b1, 1'b0, 32'h0000_1234, 6'd5, 2'd0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 32'hA,         6'd1, 1'b0, 1'b1, 32'hA,         6'd1, 2'd1, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 32'hB,         6'd2, 1'b0, 1'b1, 32'hA,         6'd1, 2'd2, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'hD,         6'd9, 1'b0, 1'b1, 32'hA,         6'd1, 2'd2, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,         6'd0, 1'b1, 1'b1, 32'hB,         6'd2, 2'd1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,         6'd0, 1'b1, 1'b0, 32'hB,         6'd2, 2'd0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 32'hA,         6'd1, 1'b0, 1'b1, 32'hA,         6'd1, 2'd1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 32'hB,         6'd2, 1'b0, 1'b1, 32'hA,         6'd1, 2'd2, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 32'hC,         6'd3, 1'b0, 1'b0, 32'hA,         6'd1, 2'd0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'h0,         6'd0, 1'b1, 1'b0, 32'hA,         6'd1, 2'd0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 32'hE,         6'd4, 1'b1, 1'b1, 32'hE,         6'd4, 2'd1, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 32'hF,         6'd7, 1'b1, 1'b1, 32'hF,         6'd7, 2'd1, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 32'h0,         6'd0, 1'b1, 1'b0, 32'hF,         6'd7, 2'd0, 1'b1};

    // Reset state, checked while reset is still held.
    #3;
    chk_outs("reset", 1'b0, '0, '0, 2'd0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table: drive at negedge, check just after the next rising edge.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      flush     = vecs[i].fl;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].idat;
      in_rd     = vecs[i].ird;
      out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      chk_outs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_dat, vecs[i].e_rd,
               vecs[i].e_occ, vecs[i].e_ir);
    end

    // Back-to-back stream 1..8 with downstream always ready.
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = k;
      in_rd     = k[RW-1:0];
      out_ready = 1'b1;
      #1;
      chk($sformatf("stream%0d.in_ready", k), {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d.out_valid", k), {63'd0, out_valid}, 64'd1);
      chk($sformatf("stream%0d.out_data", k), {32'd0, out_data}, k);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("stream_drain.occupancy", {62'd0, occupancy}, 64'd0);

    // Asynchronous reset while BUSY.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 32'h55;
    in_rd     = 6'd3;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_pre.out_valid", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_outs("arst", 1'b0, '0, '0, 2'd0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    // First accept after reset behaves as from EMPTY.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 32'h77;
    in_rd     = 6'd8;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_outs("post_arst", 1'b1, 32'h77, 6'd8, 2'd1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_arst_drain.occupancy", {62'd0, occupancy}, 64'd0);

    // Random traffic against a queue scoreboard.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      in_rd     = 6'($urandom_range(0, 63));
      #1;
      pre_acc  = in_valid & in_ready;
      pre_take = out_valid & out_ready;
      pre_hold = out_valid & ~out_ready;
      pre_out  = {out_rd, out_data};
      pre_in   = {in_rd, in_data};
      if (pre_take) begin
        if (sb_q.size() == 0) begin
          chk("rand.unexpected_output", 64'd1, 64'd0);
        end else begin
          exp_e = sb_q.pop_front();
          chk("rand.order", {26'd0, pre_out}, {26'd0, exp_e});
        end
      end
      if (pre_acc) sb_q.push_back(pre_in);
      @(posedge clk);
      #1;
      if (pre_hold) begin
        chk("rand.hold_valid", {63'd0, out_valid}, 64'd1);
        chk("rand.hold_data", {26'd0, out_rd, out_data}, {26'd0, pre_out});
      end
      chk("rand.occupancy", {62'd0, occupancy}, 64'(sb_q.size()));
    end

    // Drain whatever remains, bounded.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      #1;
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          chk("drain.unexpected_output", 64'd1, 64'd0);
        end else begin
          exp_e = sb_q.pop_front();
          chk("drain.order", {26'd0, out_rd, out_data}, {26'd0, exp_e});
        end
      end
      @(posedge clk);
    end
    #1;
    chk("drain.scoreboard_empty", 64'(sb_q.size()), 64'd0);
    chk("drain.out_valid", {63'd0, out_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
